// File: rtl/seg_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with a double-buffered frame,
// per-slot blanking gap and registered cathode/anode outputs.
module seg_scan_driver #(
    parameter int CLK_DIV   = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  dp,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int                DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  BLANK_V  = DIV_W'(BLANK_CYC);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       slot_q, slot_d;
    logic [15:0]      shadow_dig_q, shadow_dig_d;
    logic [3:0]       shadow_en_q, shadow_en_d;
    logic [3:0]       shadow_dp_q, shadow_dp_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_n_q, dp_n_d;
    logic             frame_tick_q, frame_tick_d;

    logic             frame_end;
    logic             lit;
    logic [3:0]       nib;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        unique case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            4'hF: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
        div_cnt_d    = div_cnt_q + 1'b1;
        slot_d       = slot_q;
        shadow_dig_d = shadow_dig_q;
        shadow_en_d  = shadow_en_q;
        shadow_dp_d  = shadow_dp_q;
        an_d         = 4'b1111;
        seg_d        = 7'b1111111;
        dp_n_d       = 1'b1;

        frame_end    = (div_cnt_q == DIV_LAST) && (slot_q == 2'd3);
        frame_tick_d = frame_end;
        nib          = shadow_dig_q[{slot_q, 2'b00} +: 4];
        lit          = (div_cnt_q >= BLANK_V) && shadow_en_q[slot_q];

        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            slot_d    = slot_q + 1'b1;
        end

        // Inputs are sampled only at the frame boundary so a frame never tears.
        if (frame_end) begin
            shadow_dig_d = digits;
            shadow_en_d  = digit_en;
            shadow_dp_d  = dp;
        end

        if (lit) begin
            an_d   = ~(4'b0001 << slot_q);
            seg_d  = hex7(nib);
            dp_n_d = ~shadow_dp_q[slot_q];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the frame buffer is reset
    // too, because the first frame after reset must come up dark rather than show stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q    <= '0;
            slot_q       <= 2'd0;
            shadow_dig_q <= 16'h0000;
            shadow_en_q  <= 4'b0000;
            shadow_dp_q  <= 4'b0000;
            an_q         <= 4'b1111;
            seg_q        <= 7'b1111111;
            dp_n_q       <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            slot_q       <= slot_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_en_q  <= shadow_en_d;
            shadow_dp_q  <= shadow_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: a cycle model pushes expected outputs to a
// scoreboard queue, plus table-driven hex sweep and hand-written reset/frame sequences.
module tb_seg_scan_driver;

    localparam int CLK_DIV   = 4;
    localparam int BLANK_CYC = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  digit_en;
    logic [3:0]  dp;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_tick;

    seg_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .digit_en   (digit_en),
        .dp         (dp),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] nib;
        logic [6:0] exp_seg;
    } hex_vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp_n;
        logic       ft;
    } exp_t;

    hex_vec_t sweep[16];
    exp_t     sb_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    int          m_div;
    int          m_slot;
    logic [15:0] m_dig;
    logic [3:0]  m_en;
    logic [3:0]  m_dp;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_div  = 0;
        m_slot = 0;
        m_dig  = 16'h0000;
        m_en   = 4'b0000;
        m_dp   = 4'b0000;
        cyc    = 0;
        sb_q.delete();
    endtask

    task automatic check_dark(input string name);
        check({name, "_an"},   16'(an),         16'hF);
        check({name, "_seg"},  16'(seg),        16'h7F);
        check({name, "_dp_n"}, 16'(dp_n),       16'h1);
        check({name, "_ft"},   16'(frame_tick), 16'h0);
    endtask

    // One clock: predict the next registered output, advance the model, compare after the edge.
    task automatic tick();
        exp_t       e;
        exp_t       g;
        logic       lit;
        logic [3:0] nib;
        logic       cap;
        lit  = (m_div >= BLANK_CYC) && m_en[m_slot];
        nib  = m_dig[m_slot*4 +: 4];
        cap  = (m_div == CLK_DIV - 1) && (m_slot == 3);
        e.an = 4'hF;
        e.seg = 7'h7F;
        e.dp_n = 1'b1;
        if (lit) begin
            e.an[m_slot] = 1'b0;
            e.seg  = sweep[nib].exp_seg;
            e.dp_n = !m_dp[m_slot];
        end
        e.ft = cap;
        sb_q.push_back(e);
        if (cap) begin
            m_dig = digits;
            m_en  = digit_en;
            m_dp  = dp;
        end
        m_div++;
        if (m_div == CLK_DIV) begin
            m_div  = 0;
            m_slot = (m_slot + 1) % 4;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (sb_q.size() == 0) begin
            check("sb_empty", 16'h1, 16'h0);
        end else begin
            g = sb_q.pop_front();
            check("an",         16'(an),         16'(g.an));
            check("seg",        16'(seg),        16'(g.seg));
            check("dp_n",       16'(dp_n),       16'(g.dp_n));
            check("frame_tick", 16'(frame_tick), 16'(g.ft));
        end
        check("anode_onehot", 16'($countones(~an) <= 1), 16'h1);
    endtask

    task automatic wait_ft();
        int  k;
        logic seen;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 20) begin
            tick();
            seen = frame_tick;
            k++;
        end
        if (!seen) check("frame_tick_timeout", 16'h0, 16'h1);
    endtask

    // Asynchronous reset asserted between edges, checked before the next edge.
    task automatic pulse_reset(input string name);
        #2 reset = 1'b1;
        #1 check_dark(name);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ft_cnt;
        int dp_cnt;
        int bad_an;
        int lit_cnt;
        int k;

        sweep[0]  = '{4'h0, 7'b1000000};
        sweep[1]  = '{4'h1, 7'b1111001};
        sweep[2]  = '{4'h2, 7'b0100100};
        sweep[3]  = '{4'h3, 7'b0110000};
        sweep[4]  = '{4'h4, 7'b0011001};
        sweep[5]  = '{4'h5, 7'b0010010};
        sweep[6]  = '{4'h6, 7'b0000010};
        sweep[7]  = '{4'h7, 7'b1111000};
        sweep[8]  = '{4'h8, 7'b0000000};
        sweep[9]  = '{4'h9, 7'b0010000};
        sweep[10] = '{4'hA, 7'b0001000};
        sweep[11] = '{4'hB, 7'b0000011};
        sweep[12] = '{4'hC, 7'b1000110};
        sweep[13] = '{4'hD, 7'b0100001};
        sweep[14] = '{4'hE, 7'b0000110};
        sweep[15] = '{4'hF, 7'b0001110};

        reset    = 1'b0;
        digits   = 16'h1234;
        digit_en = 4'b1111;
        dp       = 4'b0000;
        #2 reset = 1'b1;
        #1 check_dark("por");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // 1234 from reset: dark first frame, then slot-by-slot lighting
        for (int i = 0; i < 33; i++) begin
            tick();
            if (cyc <= 17) check("first_frame_dark", 16'(an), 16'hF);
            if (cyc == 16) check("first_ft", 16'(frame_tick), 16'h1);
            if (cyc == 18) begin check("s0_an", 16'(an), 16'b1110); check("s0_seg", 16'(seg), 16'b0011001); end
            if (cyc == 22) begin check("s1_an", 16'(an), 16'b1101); check("s1_seg", 16'(seg), 16'b0110000); end
            if (cyc == 26) begin check("s2_an", 16'(an), 16'b1011); check("s2_seg", 16'(seg), 16'b0100100); end
            if (cyc == 30) begin check("s3_an", 16'(an), 16'b0111); check("s3_seg", 16'(seg), 16'b1111001); end
        end

        // Mid-frame change: must not appear until the next frame
        while (cyc < 40) tick();
        digits = 16'h5678;
        ft_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (cyc >= 41 && cyc <= 48 && an == 4'b1110) check("no_tear_s0", 16'(seg), 16'b0011001);
            if (frame_tick) ft_cnt++;
        end
        check("ft_per_16", 16'(ft_cnt), 16'd2);

        // Disabled digits and decimal point
        digit_en = 4'b0101;
        dp       = 4'b0001;
        wait_ft();
        dp_cnt = 0;
        bad_an = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (!dp_n) dp_cnt++;
            if (!an[1] || !an[3]) bad_an++;
        end
        check("dp_lit_cycles", 16'(dp_cnt), 16'(CLK_DIV - BLANK_CYC));
        check("disabled_anodes", 16'(bad_an), 16'd0);

        // Reset while a digit is lit
        k = 0;
        while (an == 4'hF && k < 8) begin
            tick();
            k++;
        end
        check("lit_before_reset", 16'(an != 4'hF), 16'h1);
        pulse_reset("reset_lit");

        // Hex sweep on digit0, one table entry per frame
        digit_en = 4'b0001;
        dp       = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            digits = {12'h000, sweep[i].nib};
            wait_ft();
            lit_cnt = 0;
            for (int j = 0; j < 16; j++) begin
                tick();
                if (an == 4'b1110) begin
                    check("sweep_seg", 16'(seg), 16'(sweep[i].exp_seg));
                    lit_cnt++;
                end
            end
            check("sweep_lit_cycles", 16'(lit_cnt), 16'(CLK_DIV - BLANK_CYC));
        end

        // Reset mid-frame: restart at slot 0 with a dark first frame
        digits   = 16'hABCD;
        digit_en = 4'b1111;
        for (int i = 0; i < 7; i++) tick();
        pulse_reset("reset_mid");
        for (int i = 0; i < 16; i++) begin
            tick();
            check("post_reset_dark", 16'(an), 16'hF);
        end
        for (int i = 0; i < 20; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
